// File: rtl/sigma_delta_mod_pkg.sv
// Shared constants and types for the sigma-delta modulator.
//   DEF_DATA_WIDTH / DEF_OVERSAMPLE : parameter defaults (oversample matches the CIC decimation factor)
//   INT_GUARD / INT_WIDTH           : second-order integrator width is W + 4 signed bits
//   order_e                         : loop order selector
package sigma_delta_mod_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_OVERSAMPLE = 10;
    localparam int INT_GUARD      = 4;
    localparam int INT_WIDTH      = DEF_DATA_WIDTH + INT_GUARD;

    typedef enum logic {
        ORDER1 = 1'b0,
        ORDER2 = 1'b1
    } order_e;

    // Integrator width for an arbitrary sample width.
    function automatic int int_width(input int w);
        return w + INT_GUARD;
    endfunction

endpackage

// File: rtl/sigma_delta_mod_loop.sv
// Noise-shaping core of the modulator.
//   clk_i, rstn_i : clock, async active-low reset
//   active_i      : unsigned duty code currently being modulated
//   order_i       : 0 = first order accumulator, 1 = second order loop
//   clr_i         : zero all integrators this cycle (bit_o holds)
//   bit_o         : registered output bit, also the loop feedback
//   sat_o         : combinational pulse, a second-order integrator clamps this cycle
module sdm_loop
    import sigma_delta_mod_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [DATA_WIDTH-1:0] active_i,
    input  logic                  order_i,
    input  logic                  clr_i,
    output logic                  bit_o,
    output logic                  sat_o
);

    localparam int W  = DATA_WIDTH;
    localparam int IW = int_width(W);
    // Two extra bits so raw sums never wrap before the clamp looks at them.
    localparam int EW = IW + 2;
    localparam logic signed [EW-1:0] MAXV = EW'((1 << (IW - 1)) - 1);
    localparam logic signed [EW-1:0] MINV = ~MAXV;
    localparam logic signed [IW-1:0] HALF = IW'(1 << (W - 1));

    logic [W-1:0]          acc;
    logic [W:0]            sum;
    logic signed [IW-1:0]  i1, i2, i1_n, i2_n;
    logic signed [EW-1:0]  y, ext_act, i1_raw, i2_raw;
    logic                  sat1, sat2, second;

    function automatic logic signed [IW-1:0] clamp(input logic signed [EW-1:0] v);
        if (v > MAXV) return MAXV[IW-1:0];
        if (v < MINV) return MINV[IW-1:0];
        return v[IW-1:0];
    endfunction

    assign second = (order_e'(order_i) == ORDER2);

    // First order: carry out of the W-bit phase accumulator is the bit.
    assign sum = {1'b0, acc} + {1'b0, active_i};

    always_comb begin
        y       = '0;
        y[W]    = bit_o;             // feedback is full scale 2^W when the bit is 1
        ext_act = EW'(active_i);
        i1_raw  = EW'(i1) + ext_act - y;
        sat1    = (i1_raw > MAXV) || (i1_raw < MINV);
        i1_n    = clamp(i1_raw);
        i2_raw  = EW'(i2) + EW'(i1_n) - y;
        sat2    = (i2_raw > MAXV) || (i2_raw < MINV);
        i2_n    = clamp(i2_raw);
    end

    assign sat_o = second && !clr_i && (sat1 || sat2);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            acc   <= '0;
            i1    <= '0;
            i2    <= '0;
            bit_o <= 1'b0;
        end else if (clr_i) begin
            acc <= '0;
            i1  <= '0;
            i2  <= '0;
        end else if (second) begin
            i1    <= i1_n;
            i2    <= i2_n;
            bit_o <= (i2_n >= HALF);
        end else begin
            acc   <= sum[W-1:0];
            bit_o <= sum[W];
        end
    end

endmodule

// File: rtl/sigma_delta_mod.sv
// Sigma-delta modulator: turns an unsigned W-bit duty code into a 1-bit stream
// with ones density x/2^W, one input sample per OVERSAMPLE clocks.
//   clk_i, rstn_i   : clock, async active-low reset
//   sample_i        : duty code x, with sample_valid_i / sample_ready_o handshake
//   order_i         : loop order, picked up only at sample boundaries
//   clr_i           : clears the sticky flags (a same-cycle set wins)
//   bit_o           : modulated bitstream
//   sample_strobe_o : high in the last cycle of each sample period
//   underrun_o      : sticky, a boundary arrived with no sample pending
//   sat_o           : sticky, a second-order integrator clamped
// OVERSAMPLE is expected to be at least 2.
module sigma_delta_mod
    import sigma_delta_mod_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [DATA_WIDTH-1:0] sample_i,
    input  logic                  sample_valid_i,
    output logic                  sample_ready_o,
    input  logic                  order_i,
    input  logic                  clr_i,
    output logic                  bit_o,
    output logic                  sample_strobe_o,
    output logic                  underrun_o,
    output logic                  sat_o
);

    localparam int            CW   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] holding, active;
    logic                  pending, wrap, xfer, loop_clr, loop_sat;
    order_e                order_q;

    assign wrap            = (cnt == LAST);
    // Decoded from the counter, so it is 0 while the counter sits in reset.
    assign sample_strobe_o = wrap;
    // The holding slot frees up at the boundary, so a new sample may land
    // in the same cycle the old one moves to active.
    assign sample_ready_o  = !pending || wrap;
    assign xfer            = sample_valid_i && sample_ready_o;
    assign loop_clr        = wrap && (order_e'(order_i) != order_q);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt     <= '0;
            holding <= '0;
            active  <= '0;
            pending <= 1'b0;
            order_q <= ORDER1;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap) begin
                order_q <= order_e'(order_i);
                if (pending) active <= holding;  // otherwise last value repeats
            end
            if (xfer) holding <= sample_i;
            if (xfer)      pending <= 1'b1;
            else if (wrap) pending <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            underrun_o <= 1'b0;
            sat_o      <= 1'b0;
        end else begin
            if (wrap && !pending) underrun_o <= 1'b1;
            else if (clr_i)       underrun_o <= 1'b0;
            if (loop_sat)         sat_o <= 1'b1;
            else if (clr_i)       sat_o <= 1'b0;
        end
    end

    sdm_loop #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_loop (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .active_i (active),
        .order_i  (order_q),
        .clr_i    (loop_clr),
        .bit_o    (bit_o),
        .sat_o    (loop_sat)
    );

endmodule
